// File: rtl/parity_sched_if.sv
// parity_sched_if: request and response channels of the shared parity sequencer
interface parity_sched_if #(
  parameter int NREQ = 4,
  parameter int W = 16
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic rsp_valid;
  logic [$clog2(NREQ)-1:0] rsp_id;
  logic rsp_parity;
  logic rsp_ready;
  modport master(output req_valid, req_data, rsp_ready, input req_ready, rsp_valid, rsp_id, rsp_parity);
  modport slave(input req_valid, req_data, rsp_ready, output req_ready, rsp_valid, rsp_id, rsp_parity);
endinterface

// File: rtl/parity_sched.sv
// parity_sched: round-robin sequencer sharing one parity unit among NREQ requesters
// Define PARITY_SCHED_PRIO_EN to give requester 0 fixed top priority.
module parity_sched #(
  parameter int NREQ = 4,
  parameter int W = 16,
  parameter int LAT = 0
) (
  input  logic clk,
  input  logic rst_n,
  parity_sched_if.slave bus,
  output logic [W-1:0] par_x,
  input  logic par_f,
  output logic busy,
  output logic [15:0] ops_done
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, win;
  logic [2:0] cnt;
  logic any, accept, prio_hit;
  always_comb begin
    win = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (bus.req_valid[(int'(ptr) + k) % NREQ]) win = IW'((int'(ptr) + k) % NREQ);
`ifdef PARITY_SCHED_PRIO_EN
    prio_hit = bus.req_valid[0];
`else
    prio_hit = 1'b0;
`endif
    if (prio_hit) win = '0;
    any = |bus.req_valid;
    accept = state == IDLE && any && rst_n;
    bus.req_ready = accept ? NREQ'(1) << win : '0;
    busy = state != IDLE;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = any ? WAIT : IDLE;
      WAIT: state_nx = cnt == 3'd0 ? RESP : WAIT;
      RESP: state_nx = bus.rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      par_x <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_parity <= 1'b0;
      ops_done <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        par_x <= bus.req_data[int'(win) * W +: W];
        bus.rsp_id <= win;
        cnt <= 3'(LAT);
        if (!prio_hit) ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
      if (state == WAIT) begin
        cnt <= cnt == 3'd0 ? cnt : cnt - 3'd1;
        if (cnt == 3'd0) begin
          bus.rsp_parity <= par_f;
          bus.rsp_valid <= 1'b1;
        end
      end
      if (state == RESP && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
        ops_done <= ops_done + 16'd1;
      end
    end
endmodule

// File: tb/tb_parity_sched.sv
// tb_parity_sched: drives a LAT=0 and a LAT=3 instance against a transaction-level model
module tb_parity_sched;
`ifdef PARITY_SCHED_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [3:0] rv[2];
  logic [63:0] rd[2];
  logic rr[2];
  logic [3:0] ordy[2];
  logic ov[2], opar[2], obusy[2];
  logic [1:0] oid[2];
  logic [15:0] px[2], ops[2];
  logic [2:0] pipe = '0;
  parity_sched_if #(.NREQ(4), .W(16)) b0();
  parity_sched_if #(.NREQ(4), .W(16)) b3();
  assign b0.req_valid = rv[0];
  assign b0.req_data = rd[0];
  assign b0.rsp_ready = rr[0];
  assign b3.req_valid = rv[1];
  assign b3.req_data = rd[1];
  assign b3.rsp_ready = rr[1];
  assign ordy[0] = b0.req_ready;
  assign ov[0] = b0.rsp_valid;
  assign oid[0] = b0.rsp_id;
  assign opar[0] = b0.rsp_parity;
  assign ordy[1] = b3.req_ready;
  assign ov[1] = b3.rsp_valid;
  assign oid[1] = b3.rsp_id;
  assign opar[1] = b3.rsp_parity;
  parity_sched #(.NREQ(4), .W(16), .LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .par_x(px[0]), .par_f(^px[0]), .busy(obusy[0]), .ops_done(ops[0])
  );
  parity_sched #(.NREQ(4), .W(16), .LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .par_x(px[1]), .par_f(pipe[2]), .busy(obusy[1]), .ops_done(ops[1])
  );
  // three-stage pipelined parity unit for the LAT=3 instance
  always @(posedge clk) pipe <= {pipe[1:0], ^px[1]};
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int win(input logic [3:0] v, input int p);
    if (PRIO && v[0]) return 0;
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction
  // Model: one outstanding transaction per instance, timed from its accept cycle
  bit inflight[2];
  int acc[2], mptr[2];
  logic [1:0] mid[2];
  logic mpar[2];
  logic [15:0] mx[2], mops[2];
  int cyc = 0;
  int lat[2] = '{0, 3};
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        inflight[i] = 0; mptr[i] = 0; mid[i] = 0; mpar[i] = 0; mx[i] = 0; mops[i] = 0; acc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int w;
        w = win(rv[i], mptr[i]);
        if (!inflight[i] && w >= 0) begin
          inflight[i] = 1; acc[i] = cyc; mid[i] = 2'(w); mx[i] = rd[i][w*16 +: 16]; mpar[i] = ^mx[i];
          if (!(PRIO && w == 0)) mptr[i] = (w + 1) % 4;
        end else if (inflight[i] && cyc >= acc[i] + lat[i] + 2 && rr[i]) begin
          inflight[i] = 0; mops[i] = mops[i] + 16'd1;
        end
      end
      cyc++;
    end
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      int w;
      logic ev;
      w = win(rv[i], mptr[i]);
      ev = inflight[i] && cyc >= acc[i] + lat[i] + 2;
      chk($sformatf("req_ready%0d", i), 32'(ordy[i]), (rst_n && !inflight[i] && w >= 0) ? 32'(1 << w) : 0);
      chk($sformatf("rsp_valid%0d", i), 32'(ov[i]), 32'(ev));
      chk($sformatf("rsp_id%0d", i), 32'(oid[i]), 32'(mid[i]));
      if (ev) chk($sformatf("rsp_parity%0d", i), 32'(opar[i]), 32'(mpar[i]));
      chk($sformatf("par_x%0d", i), 32'(px[i]), 32'(mx[i]));
      chk($sformatf("busy%0d", i), 32'(obusy[i]), 32'(inflight[i]));
      chk($sformatf("ops_done%0d", i), 32'(ops[i]), 32'(mops[i]));
    end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_rsp(input int i, output int c);
    int k = 0;
    c = -1;
    do begin
      @(negedge clk);
      k++;
    end while (!ov[i] && k < 40);
    if (ov[i]) c = cyc;
    else chk("rsp_timeout", 0, 1);
  endtask
  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  int c, pc, ca;
  int fid[5] = '{0, 1, 2, 3, 0};
  int fpar[5] = '{0, 1, 0, 1, 0};
  initial begin
    rv = '{default: '0};
    rd = '{default: '0};
    rr = '{default: 1'b1};
    tick(2);
    rst_n = 1'b1;
    tick();
    rd[0][47:32] = 16'h0001;
    rv[0] = 4'b0100;
    @(negedge clk) chk("single_ready", 32'(ordy[0]), 32'h4);
    tick();
    rv[0] = '0;
    wait_rsp(0, c);
    chk("single_id", 32'(oid[0]), 2);
    chk("single_par", 32'(opar[0]), 1);
    tick();
    @(negedge clk) chk("single_ops", 32'(ops[0]), 1);
    do_reset();
    rd[0] = {16'h8000, 16'h00FF, 16'h0007, 16'h0003};
    rv[0] = 4'hF;
    pc = 0;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(0, c);
      chk("fair_id", 32'(oid[0]), 32'(fid[k]));
      chk("fair_par", 32'(opar[0]), 32'(fpar[k]));
      if (k > 0) chk("fair_gap", 32'(c - pc), 3);
      pc = c;
    end
    tick();
    rv[0] = '0;
    rd[1][15:0] = 16'hFFFE;
    rv[1] = 4'b0001;
    @(negedge clk) ca = cyc;
    chk("lat_ready", 32'(ordy[1]), 1);
    tick();
    rv[1] = '0;
    wait_rsp(1, c);
    chk("lat_edges", 32'(c - ca - 1), 4);
    chk("lat_par", 32'(opar[1]), 1);
    tick();
    rr[0] = 1'b0;
    rd[0][31:16] = 16'h1234;
    rv[0] = 4'b0010;
    tick();
    rv[0] = 4'b0001;
    wait_rsp(0, c);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", 32'(ov[0]), 1);
      chk("bp_busy", 32'(obusy[0]), 1);
      chk("bp_ready", 32'(ordy[0]), 0);
      chk("bp_id", 32'(oid[0]), 1);
      chk("bp_par", 32'(opar[0]), 1);
      @(negedge clk);
    end
    tick();
    rr[0] = 1'b1;
    @(negedge clk) chk("bp_hs_busy", 32'(obusy[0]), 1);
    @(negedge clk) chk("bp_idle_busy", 32'(obusy[0]), 0);
    chk("bp_idle_ready", 32'(ordy[0]), 1);
    tick();
    rv[0] = '0;
    wait_rsp(0, c);
    tick();
    rd[1][47:32] = 16'h00F0;
    rv[1] = 4'b0100;
    tick();
    rv[1] = '0;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(ov[1]), 0);
    chk("rst_busy", 32'(obusy[1]), 0);
    chk("rst_par_x", 32'(px[1]), 0);
    chk("rst_id", 32'(oid[1]), 0);
    chk("rst_ops", 32'(ops[1]), 0);
    chk("rst_ops0", 32'(ops[0]), 0);
    chk("rst_ready", 32'(ordy[1]), 0);
    tick();
    rst_n = 1'b1;
    rv[1] = 4'hF;
    @(negedge clk) chk("rst_first_grant", 32'(ordy[1]), 1);
    tick();
    rv[1] = '0;
    wait_rsp(1, c);
    chk("rst_first_id", 32'(oid[1]), 0);
    tick();
    do_reset();
    rv[0] = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      wait_rsp(0, c);
      chk("prio_id", 32'(oid[0]), PRIO ? 0 : 32'(k % 2));
    end
    tick();
    rv[0] = '0;
    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
